// File: rtl/hex_scroll_ctrl.sv
// Scrolling-message controller for six active-low seven-segment digits.
// Buttons give run/pause, single step and direction; display is fully registered.
module hex_scroll_ctrl #(
   parameter int unsigned DIV_MAX = 24_999_999
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] key,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3,
   output logic [6:0] hex4,
   output logic [6:0] hex5
);

   typedef enum logic {RUN, PAUSE} state_t;

   localparam logic [31:0] DIV_LAST = 32'(DIV_MAX);

   state_t      state, state_nxt;
   logic [1:0]  key_p0, key_p1, key_p2;
   logic        press0, press1, tick;
   logic [31:0] div, div_nxt;
   logic [3:0]  pos, pos_nxt, pos_step;
   logic        dir, dir_nxt;

   // Message "ASTANA__ALMATY__"; indices 6, 7, 14, 15 are blank.
   function automatic logic [6:0] glyph(input logic [3:0] idx);
      logic [6:0] seg;
      case (idx)
         4'd0, 4'd3, 4'd5, 4'd8, 4'd11: seg = 7'b0001000;  // A
         4'd1:                          seg = 7'b0010010;  // S
         4'd2, 4'd12:                   seg = 7'b0000111;  // T
         4'd4:                          seg = 7'b0101011;  // N
         4'd9:                          seg = 7'b1000111;  // L
         4'd10:                         seg = 7'b1101010;  // M
         4'd13:                         seg = 7'b0010001;  // Y
         default:                       seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // key_p0/key_p1 synchronize, key_p2 holds the previous synchronized level
   assign press0   = key_p2[0] & ~key_p1[0];
   assign press1   = key_p2[1] & ~key_p1[1];
   assign tick     = (state == RUN) && (div == DIV_LAST);
   assign pos_step = dir ? (pos - 4'd1) : (pos + 4'd1);

   always_comb begin
      state_nxt = state;
      div_nxt   = '0;
      pos_nxt   = pos;
      dir_nxt   = dir;
      case (state)
         RUN: begin
            div_nxt = tick ? '0 : (div + 32'd1);
            if (tick)   pos_nxt   = pos_step;
            if (press1) dir_nxt   = ~dir;
            if (press0) state_nxt = PAUSE;
         end
         PAUSE: begin
            if (press1) pos_nxt   = pos_step;
            if (press0) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         key_p0 <= 2'b11;
         key_p1 <= 2'b11;
         key_p2 <= 2'b11;
         div    <= '0;
         pos    <= '0;
         dir    <= 1'b0;
      end else begin
         state  <= state_nxt;
         key_p0 <= key;
         key_p1 <= key_p0;
         key_p2 <= key_p1;
         div    <= div_nxt;
         pos    <= pos_nxt;
         dir    <= dir_nxt;
      end
   end

   // Display stage: one cycle behind pos
   always_ff @(posedge clk) begin
      if (reset) begin
         hex5 <= glyph(4'd0);
         hex4 <= glyph(4'd1);
         hex3 <= glyph(4'd2);
         hex2 <= glyph(4'd3);
         hex1 <= glyph(4'd4);
         hex0 <= glyph(4'd5);
      end else begin
         hex5 <= glyph(pos);
         hex4 <= glyph(pos + 4'd1);
         hex3 <= glyph(pos + 4'd2);
         hex2 <= glyph(pos + 4'd3);
         hex1 <= glyph(pos + 4'd4);
         hex0 <= glyph(pos + 4'd5);
      end
   end

endmodule
